// File: rtl/sevenseg_demux.sv
// Receive-side monitor for a multiplexed seven-segment bus: waits for each digit's
// pattern to settle, stores it per digit and decodes it back to a hex nibble.
module sevenseg_demux #(
    parameter int N      = 2,
    parameter int STABLE = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cathod,
    input  logic [6:0]     seg_in,
    input  logic [N-1:0]   an_in,
    output logic [6:0]     digit_seg [N],
    output logic [3:0]     digit_hex [N],
    output logic [N-1:0]   hex_ok,
    output logic [N-1:0]   digit_valid,
    output logic           frame_done,
    output logic           sel_err
);

    localparam int CW = $clog2(STABLE + 1);

    typedef enum logic {SETTLE, HELD} state_t;

    state_t         state;
    logic [6:0]     segn;
    logic [N-1:0]   seln;
    logic [N+6:0]   s;
    logic [N+6:0]   p;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic [N-1:0]   mask;
    logic [N-1:0]   mask_set;
    logic [6:0]     s_seg;
    logic [N-1:0]   s_sel;
    logic           sel_onehot;
    logic           act;
    logic [4:0]     dec;

    // Returns {legal, nibble}; unknown glyphs decode to 0 and are flagged illegal.
    function automatic logic [4:0] decode(input logic [6:0] g);
        case (g)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    always_comb begin
        segn = cathod ? ~seg_in : seg_in;
        seln = cathod ? an_in : ~an_in;
    end

    // A new sample restarts the dwell count; acting on the sample that reaches
    // STABLE lets STABLE=1 capture on the first differing sample.
    always_comb begin
        s_seg      = s[N+6:N];
        s_sel      = s[N-1:0];
        sel_onehot = (s_sel != '0) && ((s_sel & (s_sel - N'(1))) == '0);
        mask_set   = mask | s_sel;
        dec        = decode(s_seg);
        if (s != p)
            cnt_next = CW'(1);
        else if (cnt >= CW'(STABLE))
            cnt_next = cnt;
        else
            cnt_next = cnt + CW'(1);
        act = ((state == SETTLE) || (s != p)) && (cnt_next == CW'(STABLE));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= SETTLE;
            s           <= '0;
            p           <= '0;
            cnt         <= '0;
            mask        <= '0;
            hex_ok      <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            sel_err     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                digit_seg[i] <= '0;
                digit_hex[i] <= '0;
            end
        end else begin
            s          <= {segn, seln};
            p          <= s;
            cnt        <= cnt_next;
            frame_done <= 1'b0;
            sel_err    <= 1'b0;
            if (act) begin
                state <= HELD;
                if (sel_onehot) begin
                    for (int i = 0; i < N; i++) begin
                        if (s_sel[i]) begin
                            digit_seg[i]   <= s_seg;
                            digit_hex[i]   <= dec[3:0];
                            hex_ok[i]      <= dec[4];
                            digit_valid[i] <= 1'b1;
                        end
                    end
                    if (mask_set == '1) begin
                        frame_done <= 1'b1;
                        mask       <= '0;
                    end else begin
                        mask <= mask_set;
                    end
                end else if (s_sel != '0) begin
                    sel_err <= 1'b1;
                end
            end else if (s != p) begin
                state <= SETTLE;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_demux.sv
// Directed bench for sevenseg_demux (N=2, STABLE=4) with hand-computed expectations,
// ending with an emulated driver loopback and a mid-frame reset.
module tb_sevenseg_demux;

    logic       clk;
    logic       reset;
    logic       cathod;
    logic [6:0] seg_in;
    logic [1:0] an_in;
    logic [6:0] digit_seg [2];
    logic [3:0] digit_hex [2];
    logic [1:0] hex_ok;
    logic [1:0] digit_valid;
    logic       frame_done;
    logic       sel_err;

    int compared   = 0;
    int mismatched = 0;
    int fdCount    = 0;
    int seCount    = 0;
    int lastFd     = -1;
    logic bothHigh = 1'b0;

    sevenseg_demux #(.N(2), .STABLE(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cathod      (cathod),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digit_seg   (digit_seg),
        .digit_hex   (digit_hex),
        .hex_ok      (hex_ok),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .sel_err     (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse bookkeeping on the falling edge, away from the capturing edge.
    always @(negedge clk) begin
        if (frame_done === 1'b1) fdCount++;
        if (sel_err === 1'b1) seCount++;
        if (frame_done === 1'b1 && sel_err === 1'b1) bothHigh = 1'b1;
    end

    task automatic applyStimulus(input logic cath, input logic [6:0] seg,
                                 input logic [1:0] an, input int cycles);
        cathod = cath;
        seg_in = seg;
        an_in  = an;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Emulated driver: digit 0 shows "4", digit 1 shows "2", 8 cycles each.
    task automatic runLoopback(input int firstCycle, input int lastCycle);
        for (int c = firstCycle; c < lastCycle; c++) begin
            cathod = 1'b0;
            if (((c / 8) % 2) == 0) begin
                seg_in = 7'h66;
                an_in  = 2'b10;
            end else begin
                seg_in = 7'h5B;
                an_in  = 2'b01;
            end
            @(posedge clk);
            #1;
            if (frame_done === 1'b1) begin
                if (lastFd >= 0) checkOutput("loop_fd_interval", c - lastFd, 16);
                lastFd = c;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 7'h00, 2'b11, 3);
        checkOutput("rst_valid", digit_valid, 0);
        checkOutput("rst_hex_ok", hex_ok, 0);
        checkOutput("rst_seg0", digit_seg[0], 0);
        checkOutput("rst_seg1", digit_seg[1], 0);
        checkOutput("rst_hex0", digit_hex[0], 0);
        checkOutput("rst_pulses", {frame_done, sel_err}, 0);

        // Digit 0 "0": capture lands exactly 4 edges after the first sample.
        reset = 1'b1;
        applyStimulus(1'b0, 7'h3F, 2'b10, 4);
        checkOutput("t1_not_yet", digit_valid, 2'b00);
        applyStimulus(1'b0, 7'h3F, 2'b10, 1);
        checkOutput("t1_seg0", digit_seg[0], 7'h3F);
        checkOutput("t1_hex0", digit_hex[0], 4'h0);
        checkOutput("t1_valid", digit_valid, 2'b01);
        applyStimulus(1'b0, 7'h3F, 2'b10, 1);
        checkOutput("t1_no_frame_yet", fdCount, 0);
        applyStimulus(1'b0, 7'h06, 2'b01, 6);
        checkOutput("t1_seg1", digit_seg[1], 7'h06);
        checkOutput("t1_hex1", digit_hex[1], 4'h1);
        checkOutput("t1_valid_both", digit_valid, 2'b11);
        checkOutput("t1_frame_count", fdCount, 1);

        // Common-cathode polarity, long dwell on digit 0 showing "E".
        applyStimulus(1'b1, ~7'h79, 2'b01, 10);
        checkOutput("t2_seg0", digit_seg[0], 7'h79);
        checkOutput("t2_hex0", digit_hex[0], 4'hE);
        checkOutput("t2_hex_ok", hex_ok, 2'b11);
        checkOutput("t2_frame_count", fdCount, 1);
        checkOutput("t2_sel_err_count", seCount, 0);

        // Three-sample glitch on digit 1, then all-off.
        applyStimulus(1'b1, ~7'h3F, 2'b10, 3);
        applyStimulus(1'b1, ~7'h3F, 2'b00, 8);
        checkOutput("t3_seg1_kept", digit_seg[1], 7'h06);
        checkOutput("t3_hex1_kept", digit_hex[1], 4'h1);
        checkOutput("t3_pulses", fdCount + seCount, 1);

        // Two digits selected at once, then all-off.
        applyStimulus(1'b1, ~7'h3F, 2'b11, 5);
        checkOutput("t4_sel_err_high", sel_err, 1'b1);
        checkOutput("t4_no_frame", frame_done, 1'b0);
        applyStimulus(1'b1, ~7'h3F, 2'b11, 1);
        checkOutput("t4_sel_err_drop", sel_err, 1'b0);
        checkOutput("t4_seg0_kept", digit_seg[0], 7'h79);
        checkOutput("t4_seg1_kept", digit_seg[1], 7'h06);
        applyStimulus(1'b1, ~7'h3F, 2'b00, 8);
        checkOutput("t4_sel_err_count", seCount, 1);

        // Illegal glyph on digit 1 completes the frame started by digit 0.
        applyStimulus(1'b0, 7'h49, 2'b01, 6);
        checkOutput("t5_seg1", digit_seg[1], 7'h49);
        checkOutput("t5_hex1", digit_hex[1], 4'h0);
        checkOutput("t5_hex_ok", hex_ok, 2'b01);
        checkOutput("t5_valid", digit_valid, 2'b11);
        checkOutput("t5_frame_count", fdCount, 2);

        // Loopback: frames at cycles 12, 28, 44.
        lastFd = -1;
        runLoopback(0, 48);
        checkOutput("loop_frame_count", fdCount, 5);
        checkOutput("loop_hex0", digit_hex[0], 4'h4);
        checkOutput("loop_hex1", digit_hex[1], 4'h2);
        checkOutput("loop_hex_ok", hex_ok, 2'b11);
        runLoopback(48, 54);
        checkOutput("loop_partial_frame", fdCount, 5);
        reset = 1'b0;
        runLoopback(54, 56);
        checkOutput("loop_rst_valid", digit_valid, 2'b00);
        checkOutput("loop_rst_hex_ok", hex_ok, 2'b00);
        checkOutput("loop_rst_hex0", digit_hex[0], 4'h0);
        checkOutput("loop_rst_seg1", digit_seg[1], 7'h00);
        reset = 1'b1;
        lastFd = -1;
        runLoopback(56, 91);
        checkOutput("loop_post_rst_frames", fdCount, 7);
        checkOutput("loop_post_rst_hex0", digit_hex[0], 4'h4);
        checkOutput("loop_post_rst_hex1", digit_hex[1], 4'h2);
        checkOutput("loop_post_rst_valid", digit_valid, 2'b11);

        checkOutput("fd_se_exclusive", bothHigh, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
